// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
//
// Round-robin arbiter for four clients in front of a single req/ack
// handshake engine. Each client pulses its cli_req bit for one cycle. The
// pulse is held in a pending register until the transaction for that client
// finishes: either the engine acks it, or the wait times out.
//
// Each winning client gets one downstream transaction:
//   IDLE  -> ISSUE  one-cycle req pulse to the engine
//   ISSUE -> WAIT   wait for ack, with a timeout of TIMEOUT cycles
//   WAIT  -> IDLE   ack received: cli_done pulse to the client
//   WAIT  -> DRAIN  timed out: cli_err pulse to the client
//   DRAIN -> IDLE   the late ack has been absorbed
//
// Parameters:
//   TIMEOUT       number of WAIT cycles without ack before abort (2..15)
//
// Ports:
//   clock         single clock; all state changes on its rising edge
//   reset_n       asynchronous active-low reset
//   cli_req[3:0]  one-cycle request pulse per client
//   cli_done[3:0] one-cycle completion pulse per client
//   cli_err[3:0]  one-cycle timeout-abort pulse per client
//   grant_id[1:0] index of the client currently being served
//   busy          high whenever the FSM is not IDLE
//   req           one-cycle request to the downstream engine
//   ack           one-cycle completion strobe from the downstream engine
//   spurious_ack  sticky flag, set by an ack seen in IDLE or ISSUE
//
// Every output is driven from a flop. No input reaches an output through
// combinational logic.
// ---------------------------------------------------------------------------
module req_arbiter #(
    parameter int unsigned TIMEOUT = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] cli_req,
    output logic [3:0] cli_done,
    output logic [3:0] cli_err,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       req,
    input  logic       ack,
    output logic       spurious_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    // Last timer value before abort. With TIMEOUT <= 15 this fits in the
    // 4-bit timer, so the timer never wraps.
    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] pending;
    logic [3:0] timer;
    logic [1:0] last_grant;

    logic [3:0] clr_mask;
    logic       rr_valid;
    logic [1:0] rr_pick;

    // Round-robin pick. The search starts at last_grant+1 and wraps modulo 4
    // through the natural 2-bit overflow. k=4 wraps back to last_grant
    // itself, so that client is tried last.
    always_comb begin
        logic [1:0] cand;
        rr_valid = 1'b0;
        rr_pick  = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!rr_valid && pending[cand]) begin
                rr_valid = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    // The served client's pending bit clears when its transaction ends in
    // WAIT (by ack or by timeout). A new cli_req in the same cycle still
    // wins, because the set term is ORed in after the clear.
    always_comb begin
        clr_mask = '0;
        if (state == WAIT && (ack || timer == TIMER_LAST)) begin
            clr_mask = 4'b0001 << grant_id;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pending      <= '0;
            timer        <= '0;
            last_grant   <= 2'd3;
            grant_id     <= '0;
            req          <= 1'b0;
            busy         <= 1'b0;
            cli_done     <= '0;
            cli_err      <= '0;
            spurious_ack <= 1'b0;
        end else begin
            // Pulse outputs default low, so each pulse lasts exactly one cycle.
            cli_done <= '0;
            cli_err  <= '0;
            req      <= 1'b0;

            pending <= (pending & ~clr_mask) | cli_req;

            if (ack && (state == IDLE || state == ISSUE)) begin
                spurious_ack <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // Only the registered pending bits are examined here, so
                    // a cli_req arriving now is considered next cycle.
                    if (rr_valid) begin
                        grant_id <= rr_pick;
                        req      <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    // ack is checked before the timer, so an ack on the
                    // final timer value counts as a completion.
                    if (ack) begin
                        cli_done   <= 4'b0001 << grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        cli_err    <= 4'b0001 << grant_id;
                        last_grant <= grant_id;
                        state      <= DRAIN;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end

                DRAIN: begin
                    // The engine still owes an ack for the aborted request.
                    // Absorb it before issuing anything new.
                    if (ack) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter
//
// Testbench for req_arbiter, built with TIMEOUT=4.
//
// A transaction-level reference model predicts every output on every cycle.
// Directed sequences check hand-derived cycle timing against literal values.
// A randomised phase then uses an engine responder with a random ack delay.
// ---------------------------------------------------------------------------
module tb_req_arbiter;

    localparam int TO = 4;

    logic       clock;
    logic       reset_n;
    logic [3:0] cli_req;
    logic [3:0] cli_done;
    logic [3:0] cli_err;
    logic [1:0] grant_id;
    logic       busy;
    logic       req;
    logic       ack;
    logic       spurious_ack;

    logic man_ack;
    logic rsp_ack;
    logic rsp_en;
    int   rsp_lo, rsp_hi, rsp_cnt;

    assign ack = man_ack | rsp_ack;

    int n_checks = 0;
    int n_fail   = 0;

    req_arbiter #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cli_req      (cli_req),
        .cli_done     (cli_done),
        .cli_err      (cli_err),
        .grant_id     (grant_id),
        .busy         (busy),
        .req          (req),
        .ack          (ack),
        .spurious_ack (spurious_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases of one transaction. waited counts the WAIT cycles already
    // spent, including the current one.
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_DRAIN = 3;
    int         m_phase  = PH_IDLE;
    int         m_waited = 0;
    int         m_last   = 3;
    int         m_gid    = 0;
    int         m_fin;
    bit         m_pend[4];
    logic [3:0] e_done = '0, e_err = '0;
    logic [1:0] e_gid = '0;
    logic       e_busy = 1'b0, e_req = 1'b0, e_spur = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = PH_IDLE; m_waited = 0; m_last = 3; m_gid = 0;
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            e_done = '0; e_err = '0; e_gid = '0;
            e_busy = 1'b0; e_req = 1'b0; e_spur = 1'b0;
        end else begin
            m_fin  = -1;
            e_done = '0;
            e_err  = '0;
            e_req  = 1'b0;
            if (ack && (m_phase == PH_IDLE || m_phase == PH_ISSUE)) e_spur = 1'b1;
            case (m_phase)
                PH_IDLE: begin
                    for (int k = 1; k <= 4; k++) begin
                        if (m_phase == PH_IDLE && m_pend[(m_last + k) % 4]) begin
                            m_gid   = (m_last + k) % 4;
                            m_phase = PH_ISSUE;
                            e_req   = 1'b1;
                        end
                    end
                end
                PH_ISSUE: begin
                    m_phase  = PH_WAIT;
                    m_waited = 0;
                end
                PH_WAIT: begin
                    m_waited++;
                    if (ack) begin
                        e_done[m_gid] = 1'b1;
                        m_fin   = m_gid;
                        m_phase = PH_IDLE;
                    end else if (m_waited == TO) begin
                        e_err[m_gid] = 1'b1;
                        m_fin   = m_gid;
                        m_phase = PH_DRAIN;
                    end
                end
                default: if (ack) m_phase = PH_IDLE;
            endcase
            if (m_fin >= 0) m_last = m_fin;
            for (int i = 0; i < 4; i++) begin
                if (cli_req[i]) m_pend[i] = 1'b1;
                else if (m_fin == i) m_pend[i] = 1'b0;
            end
            e_busy = (m_phase != PH_IDLE);
            e_gid  = 2'(m_gid);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_req = 1'b0;
    always @(posedge clock) begin
        #1;
        check("cli_done", 32'(cli_done), 32'(e_done));
        check("cli_err", 32'(cli_err), 32'(e_err));
        check("grant_id", 32'(grant_id), 32'(e_gid));
        check("busy", 32'(busy), 32'(e_busy));
        check("req", 32'(req), 32'(e_req));
        check("spurious_ack", 32'(spurious_ack), 32'(e_spur));
        check("req_back_to_back", 32'(req & prev_req), 32'd0);
        check("done_err_onehot", 32'($countones(cli_done | cli_err) <= 1), 32'd1);
        prev_req = req;
    end

    // ---------------- engine responder ----------------
    always @(negedge clock) begin
        rsp_ack = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) rsp_ack = 1'b1;
        end
        if (rsp_en && req) rsp_cnt = $urandom_range(rsp_hi, rsp_lo);
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic pulse_req(input logic [3:0] v);
        cli_req = v;
        cyc();
        cli_req = '0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!req && n < 10) begin
            cyc();
            n++;
        end
        check(nm, 32'(req), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         q[$];
        int         ndone, nerr, n, issued;
        logic [3:0] v;

        reset_n = 1'b0; cli_req = '0; man_ack = 1'b0;
        rsp_ack = 1'b0; rsp_en = 1'b0; rsp_lo = 1; rsp_hi = 1; rsp_cnt = 0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_done", 32'(cli_done), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Single request, ack on the third cycle after req.
        pulse_req(4'b0001);
        check("t1_no_req_yet", 32'(req), 32'd0);
        cyc();
        check("t1_req", 32'(req), 32'd1);
        check("t1_gid", 32'(grant_id), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        cyc();
        check("t1_req_one_cycle", 32'(req), 32'd0);
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t1_done", 32'(cli_done), 32'd1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        cyc();
        check("t1_done_pulse", 32'(cli_done), 32'd0);

        // All four clients at once, immediate-ack engine.
        do_reset();
        rsp_en = 1'b1; rsp_lo = 1; rsp_hi = 1;
        ndone = 0; nerr = 0; n = 0;
        pulse_req(4'b1111);
        while (!(q.size() == 4 && !busy) && n < 60) begin
            cyc();
            n++;
            if (req) q.push_back(int'(grant_id));
            ndone += $countones(cli_done);
            nerr  += $countones(cli_err);
        end
        check("t2_grants", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4 && i < q.size(); i++) check("t2_order", 32'(q[i]), 32'(i));
        check("t2_dones", 32'(ndone), 32'd4);
        check("t2_errs", 32'(nerr), 32'd0);
        rsp_en = 1'b0;
        repeat (3) cyc();

        // Timeout, then a late ack that clears DRAIN.
        pulse_req(4'b0001);
        wait_req("t3_req");
        repeat (4) cyc();
        check("t3_no_err_early", 32'(cli_err), 32'd0);
        cyc();
        check("t3_err", 32'(cli_err), 32'd1);
        check("t3_drain_busy", 32'(busy), 32'd1);
        repeat (4) cyc();
        check("t3_drain_hold", 32'(busy), 32'd1);
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_no_done", 32'(cli_done), 32'd0);
        check("t3_not_spurious", 32'(spurious_ack), 32'd0);

        // An ack on the last WAIT cycle is a completion, not an abort.
        pulse_req(4'b0100);
        wait_req("t4_req");
        check("t4_gid", 32'(grant_id), 32'd2);
        repeat (4) cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t4_done", 32'(cli_done), 32'b0100);
        check("t4_err", 32'(cli_err), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);

        // Spurious ack in IDLE, then reset in the middle of WAIT.
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t5_spur", 32'(spurious_ack), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_gid", 32'(grant_id), 32'd2);
        repeat (3) cyc();
        check("t5_sticky", 32'(spurious_ack), 32'd1);
        pulse_req(4'b1010);
        wait_req("t5_req");
        check("t5_gid_next", 32'(grant_id), 32'd3);
        cyc();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_spur", 32'(spurious_ack), 32'd0);
        check("t5_rst_gid", 32'(grant_id), 32'd0);
        check("t5_rst_pulses", 32'({cli_done, cli_err}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) cyc();
        check("t5_pending_gone", 32'(busy), 32'd0);

        // Random traffic against an engine with a random ack delay. Delays
        // longer than TO cycles force timeouts followed by DRAIN.
        do_reset();
        rsp_en = 1'b1; rsp_lo = 1; rsp_hi = 7;
        issued = 0;
        while (issued < 1000) begin
            if ($urandom_range(3, 0) == 0) begin
                v = 4'($urandom_range(15, 1));
                issued += $countones(v);
                cli_req = v;
            end else begin
                cli_req = '0;
            end
            cyc();
        end
        cli_req = '0;
        n = 0;
        while ((busy || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) && n < 300) begin
            cyc();
            n++;
        end
        check("t6_drained", 32'(busy), 32'd0);
        check("t6_spur", 32'(spurious_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 12, number of WAIT cycles without ack before abort; legal range 2..15.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: cli_req  input  4  one-cycle request pulse per client i (bit i).
REQ-005 Port: cli_done  output  4  one-cycle pulse to client i on successful completion.
REQ-006 Port: cli_err  output  4  one-cycle pulse to client i on timeout abort.
REQ-007 Port: grant_id  output  2  index of the client currently being served.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: req  output  1  request to the downstream req/ack handshake engine.
REQ-010 Port: ack  input  1  one-cycle completion strobe from the downstream engine.
REQ-011 Port: spurious_ack  output  1  sticky flag; ack received outside WAIT/DRAIN.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 pending[3:0] SHALL capture cli_req pulses: pending[i] set on cli_req[i]=1 and cleared when client i completes or aborts; if set and clear occur in the same cycle, set wins.
REQ-014 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DRAIN.
REQ-015 IDLE: if any pending bit is set, choose client by round-robin starting at (last_grant+1) mod 4, load grant_id, go to ISSUE; else stay in IDLE.
REQ-016 A cli_req pulse arriving while in IDLE SHALL be eligible for selection no earlier than the following cycle (pending registered first).
REQ-017 ISSUE: req SHALL be 1 for exactly this one cycle; next state WAIT; timer cleared to 0.
REQ-018 req SHALL be 0 in every state other than ISSUE, so the downstream engine never sees a held request.
REQ-019 WAIT with ack=1: pulse cli_done[grant_id] next cycle, clear pending[grant_id], last_grant<=grant_id, go to IDLE.
REQ-020 WAIT with ack=0: timer increments; when timer==TIMEOUT-1, pulse cli_err[grant_id], clear pending[grant_id], last_grant<=grant_id, go to DRAIN.
REQ-021 If ack=1 arrives in the same cycle the timer reaches TIMEOUT-1, ack SHALL win (done, not err).
REQ-022 DRAIN: hold until ack=1 (stale completion), then go to IDLE with no cli_done pulse; DRAIN has no timeout.
REQ-023 ack=1 in IDLE or ISSUE SHALL be ignored for FSM purposes and SHALL set spurious_ack until reset.
REQ-024 timer SHALL be 4 bits and never wrap; it is only meaningful in WAIT.
REQ-025 At most one bit of cli_done|cli_err SHALL be set in any cycle.
REQ-026 Minimum grant-to-grant spacing: ISSUE, WAIT (one or more cycles), IDLE; two back-to-back requests are never issued in consecutive cycles.

Reset
REQ-027 While reset_n=0: state=IDLE, pending=0, timer=0, last_grant=3 (so client 0 is first), grant_id=0, req=0, busy=0, cli_done=0, cli_err=0, spurious_ack=0.
REQ-028 Reset asserted mid-transaction SHALL discard all pending requests with no done/err pulse; deassertion takes effect on the next posedge clock.

Verification
REQ-029 After reset, cli_req=4'b0001 one cycle; responder acks 3 cycles after req -> req high one cycle, grant_id=0, cli_done=4'b0001 one cycle, busy falls after.
REQ-030 cli_req=4'b1111 simultaneously, immediate-ack responder -> grant order 0,1,2,3, four cli_done pulses, no cli_err.
REQ-031 TIMEOUT=4, responder never acks -> cli_err[grant_id] pulse after 4 WAIT cycles, FSM in DRAIN; later ack returns to IDLE with no cli_done.
REQ-032 Ack in same cycle timer reaches TIMEOUT-1 -> cli_done pulse, cli_err stays 0.
REQ-033 ack pulsed while IDLE -> spurious_ack=1 sticky, state unchanged; reset_n low mid-WAIT -> all outputs 0, pending cleared.
REQ-034 Connected to the existing req/ack engine with random slave delay, 1000 random cli_req pulses -> every request gets exactly one done or err, req never high two cycles in a row.
